alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (6-bit ALUFun, Sign, 32-bit A/B/Z) between two requesters, e.g. the EX stage and a branch/compare unit.
- Round-robin arbitration, valid/ready handshake on both requests, one registered result slot with backpressure.
- Drives the ALU operand/function inputs from the granted requester and captures Z at the end of the grant cycle.
- Keeps per-requester grant counters for performance debug.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- FUN_W, 6, ALU function-code width.
- CNT_W, 16, width of each grant counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- r0_valid  in  1  requester 0 has an operation.
- r0_ready  out  1  requester 0 operation accepted this cycle.
- r0_a, r0_b  in  WIDTH  requester 0 operands.
- r0_fun  in  FUN_W  requester 0 ALUFun code.
- r0_sign  in  1  requester 0 signed-compare select.
- r1_valid, r1_ready, r1_a, r1_b, r1_fun, r1_sign  as r0_*, for requester 1.
- alu_a, alu_b  out  WIDTH  ALU operands.
- alu_fun  out  FUN_W  ALU function code.
- alu_sign  out  1  ALU Sign input.
- alu_z  in  WIDTH  ALU result (combinational from alu_*).
- rsp_valid  out  1  result slot full.
- rsp_id  out  1  requester that owns the result.
- rsp_z  out  WIDTH  registered result.
- rsp_ready  in  1  consumer takes the result this cycle.
- grant_cnt0, grant_cnt1  out  CNT_W  saturating grant counts.

Behaviour:
- Reset values (sync, all outputs):
  - rsp_valid=0, rsp_id=0, rsp_z=0.
  - grant_cnt0=grant_cnt1=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Reset dominates every other event in the same cycle; a held result is discarded and no grant is issued.
- Slot free: can_accept = !rsp_valid || rsp_ready. A result can drain and a new op be granted in the same cycle, giving a throughput of 1 op/cycle.
- Grant (combinational, only when can_accept):
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - Neither valid: no grant.
- rN_ready=1 only for the granted requester in that cycle. It may depend combinationally on rN_valid; requesters must not make valid depend on ready.
- ALU drive:
  - alu_a/alu_b/alu_fun/alu_sign = granted requester's fields, passed through unmodified.
  - With no grant: all zero (ALUFun 000000 = ADD, harmless).
- On grant edge:
  - rsp_z <= alu_z; rsp_id <= granted id; rsp_valid <= 1.
  - last_grant <= granted id.
  - grant_cntN <= grant_cntN+1, saturating at all-ones (no wrap).
- No grant while rsp_valid && rsp_ready: rsp_valid <= 0. rsp_z and rsp_id hold their last values.
- rsp_valid && !rsp_ready: rsp_z/rsp_id hold stable, both readys stay 0, and pending requesters wait with inputs held.
- Latency: request accepted in cycle T -> result visible on rsp_* in cycle T+1.
- Fairness: under continuous contention with rsp_ready=1, grants strictly alternate; the maximum wait is 1 grant.
- No state machine beyond the slot: EMPTY (rsp_valid=0) and FULL (rsp_valid=1), with transitions exactly as above.

Test Plan:
- Reset, then r0 only with a=5, b=3, fun=000000, rsp_ready=1 -> r0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_z=0x00000008, grant_cnt0=1.
- r1 SUB a=3, b=5, fun=000001 -> rsp_z=0xFFFFFFFE, rsp_id=1.
- Both valid continuously for 6 cycles, rsp_ready=1 -> grant order 0,1,0,1,0,1; rsp_valid stays 1; each counter = 3.
- Slot full with rsp_ready=0 for 4 cycles, both valid -> r0_ready=r1_ready=0; rsp_z unchanged; when rsp_ready rises, drain and new grant occur in the same cycle.
- Assert reset while rsp_valid=1 and r0_valid=1 -> next cycle rsp_valid=0, counters 0, no ready asserted during the reset cycle; first grant after reset goes to r0 on a tie.
- CNT_W=2, 5 grants to r0 -> grant_cnt0 reads 1,2,3,3,3 (saturates, no wrap).

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Purpose : round-robin share of one combinational ALU between two requesters,
//           with a single registered result slot and per-requester grant counters.
// Latency : request accepted in cycle T, result on rsp_* in cycle T+1.
// Backpressure: a full slot with rsp_ready low blocks all grants; both readys stay low.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   r0_* / r1_*           - requester valid/ready handshake plus ALU operands
//   alu_a/b/fun/sign      - drive to the shared ALU (zero when nothing granted)
//   alu_z                 - combinational ALU result
//   rsp_valid/id/z/ready  - registered result slot and its consumer handshake
//   grant_cnt0/1          - saturating per-requester grant counters
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int FUN_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [FUN_W-1:0] r0_fun,
    input  logic             r0_sign,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [FUN_W-1:0] r1_fun,
    input  logic             r1_sign,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FUN_W-1:0] alu_fun,
    output logic             alu_sign,
    input  logic [WIDTH-1:0] alu_z,

    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_z,
    input  logic             rsp_ready,

    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    logic last_grant;
    logic can_accept;
    logic gnt_vld;
    logic gnt_id;

    // The slot can take a new result if it is empty or being drained this cycle.
    assign can_accept = !rsp_valid || rsp_ready;

    // Reset suppresses the grant so no ready is seen during the reset cycle.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (!reset && can_accept) begin
            if (r0_valid && r1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = ~last_grant;
            end else if (r0_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end else if (r1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign r0_ready = gnt_vld && !gnt_id;
    assign r1_ready = gnt_vld &&  gnt_id;

    // With no grant the ALU sees all zeros (an ADD of zeros), keeping its inputs quiet.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_fun  = '0;
        alu_sign = 1'b0;
        if (r0_ready) begin
            alu_a    = r0_a;
            alu_b    = r0_b;
            alu_fun  = r0_fun;
            alu_sign = r0_sign;
        end else if (r1_ready) begin
            alu_a    = r1_a;
            alu_b    = r1_b;
            alu_fun  = r1_fun;
            alu_sign = r1_sign;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_z      <= '0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            last_grant <= 1'b1;   // requester 0 wins the first tie
        end else if (gnt_vld) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= gnt_id;
            rsp_z      <= alu_z;
            last_grant <= gnt_id;
            if (!gnt_id && (grant_cnt0 != {CNT_W{1'b1}}))
                grant_cnt0 <= grant_cnt0 + 1'b1;
            if (gnt_id && (grant_cnt1 != {CNT_W{1'b1}}))
                grant_cnt1 <= grant_cnt1 + 1'b1;
        end else if (rsp_valid && rsp_ready) begin
            // Drain with nothing to replace it; id and data keep their last values.
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios with a small stand-in ALU.
// A second instance with 2-bit counters exercises counter saturation.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r1_valid, r0_ready, r1_ready;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic [5:0]  r0_fun, r1_fun;
    logic        r0_sign, r1_sign;
    logic [31:0] alu_a, alu_b, alu_z;
    logic [5:0]  alu_fun;
    logic        alu_sign;
    logic        rsp_valid, rsp_id, rsp_ready;
    logic [31:0] rsp_z;
    logic [15:0] grant_cnt0, grant_cnt1;

    // Saturation instance signals
    logic        s_r0_valid, s_r0_ready, s_r1_ready;
    logic [31:0] s_alu_a, s_alu_b, s_alu_z, s_rsp_z;
    logic [5:0]  s_alu_fun;
    logic        s_alu_sign, s_rsp_valid, s_rsp_id;
    logic [1:0]  s_cnt0, s_cnt1;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // Stand-in ALU: ADD (000000), SUB (000001), XOR otherwise.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [5:0] f);
        if (f == 6'b000000)      return a + b;
        else if (f == 6'b000001) return a - b;
        else                     return a ^ b;
    endfunction

    assign alu_z   = alu_model(alu_a, alu_b, alu_fun);
    assign s_alu_z = alu_model(s_alu_a, s_alu_b, s_alu_fun);

    alu_share_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_fun(r0_fun), .r0_sign(r0_sign),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_fun(r1_fun), .r1_sign(r1_sign),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
        .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_ready(rsp_ready),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    alu_share_arbiter #(.WIDTH(32), .FUN_W(6), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .r0_valid(s_r0_valid), .r0_ready(s_r0_ready), .r0_a(32'd1), .r0_b(32'd2),
        .r0_fun(6'b000000), .r0_sign(1'b0),
        .r1_valid(1'b0), .r1_ready(s_r1_ready), .r1_a(32'd0), .r1_b(32'd0),
        .r1_fun(6'b000000), .r1_sign(1'b0),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_fun(s_alu_fun), .alu_sign(s_alu_sign),
        .alu_z(s_alu_z),
        .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_z(s_rsp_z), .rsp_ready(1'b1),
        .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid);
        else passed++;
        total++;
        if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id got %0b want 0", rsp_id);
        else passed++;
        total++;
        if (rsp_z !== 32'h0) $display("FAIL reset_rsp_z got %h want 0", rsp_z);
        else passed++;
        total++;
        if ({grant_cnt0, grant_cnt1} !== 32'h0)
            $display("FAIL reset_counters got %0d/%0d want 0/0", grant_cnt0, grant_cnt1);
        else passed++;
        #1;
        total++;
        if ({r0_ready, r1_ready, alu_a, alu_fun} !== 40'h0)
            $display("FAIL idle_outputs ready=%b%b alu_a=%h fun=%b want all zero",
                     r0_ready, r1_ready, alu_a, alu_fun);
        else passed++;
    endtask

    task automatic test_single_r0();
        r0_valid = 1'b1; r0_a = 32'd5; r0_b = 32'd3; r0_fun = 6'b000000; r0_sign = 1'b1;
        rsp_ready = 1'b1;
        #1;
        total++;
        if ({r0_ready, r1_ready} !== 2'b10)
            $display("FAIL r0_only_ready got r0=%b r1=%b want 1/0", r0_ready, r1_ready);
        else passed++;
        total++;
        if ({alu_a, alu_b, alu_sign} !== {32'd5, 32'd3, 1'b1})
            $display("FAIL r0_alu_drive got a=%h b=%h s=%b want 5/3/1", alu_a, alu_b, alu_sign);
        else passed++;
        step();
        r0_valid = 1'b0; r0_sign = 1'b0;
        total++;
        if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 1'b0, 32'h8})
            $display("FAIL r0_result got v=%b id=%b z=%h want 1/0/00000008",
                     rsp_valid, rsp_id, rsp_z);
        else passed++;
        total++;
        if (grant_cnt0 !== 16'd1) $display("FAIL r0_count got %0d want 1", grant_cnt0);
        else passed++;
    endtask

    task automatic test_single_r1();
        r1_valid = 1'b1; r1_a = 32'd3; r1_b = 32'd5; r1_fun = 6'b000001; r1_sign = 1'b0;
        #1;
        total++;
        if ({r0_ready, r1_ready} !== 2'b01)
            $display("FAIL r1_only_ready got r0=%b r1=%b want 0/1", r0_ready, r1_ready);
        else passed++;
        step();
        r1_valid = 1'b0;
        total++;
        if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 1'b1, 32'hFFFF_FFFE})
            $display("FAIL r1_sub_result got v=%b id=%b z=%h want 1/1/fffffffe",
                     rsp_valid, rsp_id, rsp_z);
        else passed++;
        step();   // drain with no new request
        total++;
        if ({rsp_valid, rsp_id, rsp_z} !== {1'b0, 1'b1, 32'hFFFF_FFFE})
            $display("FAIL drain_hold got v=%b id=%b z=%h want 0/1/fffffffe",
                     rsp_valid, rsp_id, rsp_z);
        else passed++;
    endtask

    task automatic test_alternate();
        logic exp_id;
        do_reset();
        r0_a = 32'd10; r0_b = 32'd1; r0_fun = 6'b000000;   // 11
        r1_a = 32'd10; r1_b = 32'd1; r1_fun = 6'b000001;   // 9
        r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_id = i[0];
            #1;
            total++;
            if ({r0_ready, r1_ready} !== {~exp_id, exp_id})
                $display("FAIL alt_ready[%0d] got r0=%b r1=%b want grant to %0d",
                         i, r0_ready, r1_ready, exp_id);
            else passed++;
            step();
            total++;
            if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, exp_id, (exp_id ? 32'd9 : 32'd11)})
                $display("FAIL alt_result[%0d] got v=%b id=%b z=%0d want 1/%0d/%0d",
                         i, rsp_valid, rsp_id, rsp_z, exp_id, exp_id ? 9 : 11);
            else passed++;
        end
        total++;
        if ({grant_cnt0, grant_cnt1} !== {16'd3, 16'd3})
            $display("FAIL alt_counts got %0d/%0d want 3/3", grant_cnt0, grant_cnt1);
        else passed++;
    endtask

    // Continues from test_alternate: slot holds id 1, z=9; both still valid.
    task automatic test_backpressure();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({r0_ready, r1_ready} !== 2'b00)
                $display("FAIL bp_ready[%0d] got r0=%b r1=%b want 0/0", i, r0_ready, r1_ready);
            else passed++;
            step();
            total++;
            if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 1'b1, 32'd9})
                $display("FAIL bp_hold[%0d] got v=%b id=%b z=%0d want 1/1/9",
                         i, rsp_valid, rsp_id, rsp_z);
            else passed++;
        end
        rsp_ready = 1'b1;
        #1;
        total++;
        if ({r0_ready, r1_ready} !== 2'b10)
            $display("FAIL bp_release_ready got r0=%b r1=%b want 1/0", r0_ready, r1_ready);
        else passed++;
        step();
        total++;
        if ({rsp_valid, rsp_id, rsp_z, grant_cnt0} !== {1'b1, 1'b0, 32'd11, 16'd4})
            $display("FAIL bp_release_result got v=%b id=%b z=%0d cnt0=%0d want 1/0/11/4",
                     rsp_valid, rsp_id, rsp_z, grant_cnt0);
        else passed++;
    endtask

    // Slot is full here; reset must win over both the held result and a pending request.
    task automatic test_reset_mid();
        r1_valid = 1'b0; r0_valid = 1'b1; rsp_ready = 1'b0;
        reset = 1'b1;
        #1;
        total++;
        if ({r0_ready, r1_ready} !== 2'b00)
            $display("FAIL reset_cycle_ready got r0=%b r1=%b want 0/0", r0_ready, r1_ready);
        else passed++;
        step();
        reset = 1'b0;
        total++;
        if ({rsp_valid, grant_cnt0, grant_cnt1} !== {1'b0, 16'd0, 16'd0})
            $display("FAIL reset_mid_state got v=%b cnt=%0d/%0d want 0/0/0",
                     rsp_valid, grant_cnt0, grant_cnt1);
        else passed++;
        r1_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        total++;
        if ({r0_ready, r1_ready} !== 2'b10)
            $display("FAIL post_reset_tie got r0=%b r1=%b want 1/0", r0_ready, r1_ready);
        else passed++;
        step();
        r0_valid = 1'b0; r1_valid = 1'b0;
        total++;
        if ({rsp_valid, rsp_id} !== 2'b10)
            $display("FAIL post_reset_result got v=%b id=%b want 1/0", rsp_valid, rsp_id);
        else passed++;
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        s_r0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (s_cnt0 !== exp_cnt[i])
                $display("FAIL sat_cnt0[%0d] got %0d want %0d", i, s_cnt0, exp_cnt[i]);
            else passed++;
        end
        s_r0_valid = 1'b0;
        total++;
        if ({s_rsp_id, s_rsp_z} !== {1'b0, 32'd3})
            $display("FAIL sat_result got id=%b z=%0d want 0/3", s_rsp_id, s_rsp_z);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
        r0_a = '0; r0_b = '0; r0_fun = '0; r0_sign = 1'b0;
        r1_a = '0; r1_b = '0; r1_fun = '0; r1_sign = 1'b0;
        s_r0_valid = 1'b0;
        #1;
        test_reset();
        test_single_r0();
        test_single_r1();
        test_alternate();
        test_backpressure();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
